// File: rtl/sw_lap_controller_pkg.sv
// Shared encodings and default timing constants for the stopwatch lap controller.
package sw_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_COUNT = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_LAP   = 2'b11;

  localparam int DEF_CLK_HZ       = 50_000_000;
  localparam int DEF_TICK_HZ      = 100;
  localparam int DEF_DEBOUNCE_CYC = 1_000_000;

  typedef struct packed {
    logic lap;
    logic stop;
    logic start;
  } press_t;

endpackage

// File: rtl/sw_lap_controller_if.sv
// Bundle of the stopwatch button inputs and datapath control outputs.
interface sw_lap_controller_if;
  logic       start_pause;
  logic       stop;
  logic       lap;
  logic       cnt_en;
  logic       cnt_clr;
  logic       lap_load;
  logic       disp_sel;
  logic [1:0] state;

  modport master (
    output start_pause, stop, lap,
    input  cnt_en, cnt_clr, lap_load, disp_sel, state
  );

  modport slave (
    input  start_pause, stop, lap,
    output cnt_en, cnt_clr, lap_load, disp_sel, state
  );
endinterface

// File: rtl/sw_btn_debounce.sv
// Button conditioner: 2-flop synchronizer, counting debouncer, registered press pulse.
module sw_btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q;

  // Any cycle where the synchronized level agrees with the stable one restarts the run.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) stable_d = sync2_q;
      else                   cnt_d    = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= stable_d & ~stable_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/sw_lap_controller.sv
// Stopwatch control: button conditioning, run/pause/lap FSM, tick prescaler, output decode.
module sw_lap_controller
  import sw_pkg::*;
#(
  parameter int CLK_HZ       = DEF_CLK_HZ,
  parameter int TICK_HZ      = DEF_TICK_HZ,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start_pause,
  input  logic       i_stop,
  input  logic       i_lap,
  output logic       o_cnt_en,
  output logic       o_cnt_clr,
  output logic       o_lap_load,
  output logic       o_disp_sel,
  output logic [1:0] o_state
);

  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  press_t        press;
  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          lap_load_q, lap_load_d;
  logic          running, tick;

  sw_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_start (
    .clk(clk), .rst_n(rst_n), .btn_i(i_start_pause), .press_o(press.start)
  );
  sw_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_stop (
    .clk(clk), .rst_n(rst_n), .btn_i(i_stop), .press_o(press.stop)
  );
  sw_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_lap (
    .clk(clk), .rst_n(rst_n), .btn_i(i_lap), .press_o(press.lap)
  );

  // Priority start > stop > lap falls out of the if/else order in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (press.start) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if      (press.start) state_d = ST_PAUSE;
        else if (press.stop)  state_d = ST_IDLE;
        else if (press.lap)   state_d = ST_LAP;
      end
      ST_LAP: begin
        if      (press.start) state_d = ST_PAUSE;
        else if (press.stop)  state_d = ST_IDLE;
        else if (press.lap)   state_d = ST_COUNT;
      end
      ST_PAUSE: begin
        if      (press.start) state_d = ST_COUNT;
        else if (press.stop)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign running = (state_q == ST_COUNT) || (state_q == ST_LAP);
  assign tick    = running && (presc_q == PRESC_LAST);

  // PAUSE holds the partial period so a resume finishes it rather than restarting.
  always_comb begin
    presc_d = presc_q;
    if (state_d == ST_IDLE) presc_d = '0;
    else if (tick)          presc_d = '0;
    else if (running)       presc_d = presc_q + PW'(1);
  end

  assign lap_load_d = (state_q == ST_COUNT) && (state_d == ST_LAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      lap_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      lap_load_q <= lap_load_d;
    end
  end

  assign o_state    = state_q;
  assign o_cnt_en   = tick;
  assign o_cnt_clr  = (state_q == ST_IDLE);
  assign o_disp_sel = (state_q == ST_LAP);
  assign o_lap_load = lap_load_q;

endmodule

// File: tb/tb_sw_lap_controller.sv
// Bench for sw_lap_controller: spec-level model compared every cycle, plus directed scenarios.
module tb_sw_lap_controller;
  import sw_pkg::*;

  localparam int CLK_HZ   = 100;
  localparam int TICK_HZ  = 10;
  localparam int DEB      = 4;
  localparam int PRESCALE = CLK_HZ / TICK_HZ;
  localparam logic [2:0] B_START = 3'b001;
  localparam logic [2:0] B_STOP  = 3'b010;
  localparam logic [2:0] B_LAP   = 3'b100;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sw_lap_controller_if bus();

  sw_lap_controller #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_start_pause(bus.start_pause),
    .i_stop(bus.stop),
    .i_lap(bus.lap),
    .o_cnt_en(bus.cnt_en),
    .o_cnt_clr(bus.cnt_clr),
    .o_lap_load(bus.lap_load),
    .o_disp_sel(bus.disp_sel),
    .o_state(bus.state)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A button's stable level flips once the last DEB synchronized samples (2 edges old)
  // all disagree with it; FSM reacts to the press one edge later.
  logic [1:0]     m_state    = ST_IDLE;
  int             m_phase    = 0;
  logic           m_lap_load = 1'b0;
  logic [2:0]     m_stable   = '0;
  logic [2:0]     m_press    = '0;
  logic [DEB+1:0] m_hist [3];

  function automatic logic [1:0] fsm_next(input logic [1:0] st, input logic [2:0] p);
    if (p[0]) return (st == ST_IDLE || st == ST_PAUSE) ? ST_COUNT : ST_PAUSE;
    if (p[1]) return ST_IDLE;
    if (p[2]) begin
      if (st == ST_COUNT) return ST_LAP;
      if (st == ST_LAP)   return ST_COUNT;
    end
    return st;
  endfunction

  task automatic model_reset();
    m_state    = ST_IDLE;
    m_phase    = 0;
    m_lap_load = 1'b0;
    m_stable   = '0;
    m_press    = '0;
    for (int b = 0; b < 3; b++) m_hist[b] = '0;
  endtask

  task automatic model_step();
    logic [2:0] raw;
    logic [1:0] nxt;
    int         ph;
    bit         run;
    raw = {bus.lap, bus.stop, bus.start_pause};
    nxt = fsm_next(m_state, m_press);
    run = (m_state == ST_COUNT) || (m_state == ST_LAP);
    ph  = run ? (m_phase + 1) % PRESCALE : m_phase;
    if (nxt == ST_IDLE) ph = 0;
    m_lap_load = (m_state == ST_COUNT) && (nxt == ST_LAP);
    m_state    = nxt;
    m_phase    = ph;
    for (int b = 0; b < 3; b++) begin
      m_hist[b]  = {m_hist[b][DEB:0], raw[b]};
      m_press[b] = 1'b0;
      if (!m_stable[b] && (&m_hist[b][DEB+1:2])) begin
        m_stable[b] = 1'b1;
        m_press[b]  = 1'b1;
      end else if (m_stable[b] && !(|m_hist[b][DEB+1:2])) begin
        m_stable[b] = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    automatic bit run = (m_state == ST_COUNT) || (m_state == ST_LAP);
    check("state",    int'(bus.state),    int'(m_state));
    check("cnt_en",   int'(bus.cnt_en),   int'(run && m_phase == PRESCALE - 1));
    check("cnt_clr",  int'(bus.cnt_clr),  int'(m_state == ST_IDLE));
    check("disp_sel", int'(bus.disp_sel), int'(m_state == ST_LAP));
    check("lap_load", int'(bus.lap_load), int'(m_lap_load));
  end

  // ---------------- observation trackers ----------------
  int         tick_count = 0;
  int         lap_loads  = 0;
  int         run_k      = 0;
  int         first_tick = 0;
  logic [1:0] prev_state = ST_IDLE;

  always @(negedge clk) begin
    if (bus.state == ST_COUNT && prev_state != ST_COUNT && prev_state != ST_LAP) begin
      run_k      = 1;
      first_tick = 0;
    end else if (bus.state == ST_COUNT || bus.state == ST_LAP) begin
      run_k++;
    end
    if (bus.cnt_en) begin
      tick_count++;
      if (first_tick == 0) first_tick = run_k;
    end
    if (bus.lap_load) lap_loads++;
    prev_state = bus.state;
  end

  // ---------------- driver tasks ----------------
  task automatic set_buttons(input logic [2:0] m);
    bus.start_pause = m[0];
    bus.stop        = m[1];
    bus.lap         = m[2];
  endtask

  task automatic press_hold(input logic [2:0] m, input int hold);
    set_buttons(m);
    repeat (hold) @(negedge clk);
    set_buttons(3'b000);
  endtask

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.cnt_en) seen = 1;
    end
    check("wait_tick_timeout", int'(seen), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, l0, lat;
    set_buttons(3'b000);

    // Reset state
    @(negedge clk);
    check("rst_state",    int'(bus.state),    0);
    check("rst_cnt_clr",  int'(bus.cnt_clr),  1);
    check("rst_cnt_en",   int'(bus.cnt_en),   0);
    check("rst_lap_load", int'(bus.lap_load), 0);
    check("rst_disp_sel", int'(bus.disp_sel), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Glitch shorter than the debounce window, then a just-long-enough press
    press_hold(B_START, 3);
    repeat (12) @(negedge clk);
    check("glitch_ignored", int'(bus.state), int'(ST_IDLE));
    press_hold(B_START, 4);
    repeat (8) @(negedge clk);
    check("min_press_count", int'(bus.state), int'(ST_COUNT));
    press_hold(B_STOP, 8);
    repeat (6) @(negedge clk);
    check("stop_to_idle", int'(bus.state), int'(ST_IDLE));

    // Start held 10 cycles: one pulse, COUNT 7 cycles after press, first tick 10th COUNT cycle
    set_buttons(B_START);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) set_buttons(3'b000);
      if (bus.state == ST_COUNT && lat == 0) lat = i;
    end
    #1;
    check("start_latency", lat, 7);
    check("held_single_pulse", int'(bus.state), int'(ST_COUNT));
    check("first_tick_idle_start", first_tick, 10);
    t0 = tick_count;
    repeat (30) @(negedge clk);
    #1;
    check("tick_period_count", tick_count - t0, 3);

    // Pause with prescaler at 6 on the pulse cycle, resume after 50 cycles
    wait_tick();
    @(negedge clk);
    press_hold(B_START, 8);
    check("paused", int'(bus.state), int'(ST_PAUSE));
    t0 = tick_count;
    repeat (50) @(negedge clk);
    #1;
    check("no_ticks_paused", tick_count - t0, 0);
    press_hold(B_START, 8);
    repeat (5) @(negedge clk);
    #1;
    check("resume_first_tick", first_tick, 3);

    // Lap entry and exit
    l0 = lap_loads;
    press_hold(B_LAP, 8);
    #1;
    check("lap_state", int'(bus.state), int'(ST_LAP));
    check("lap_disp_sel", int'(bus.disp_sel), 1);
    check("lap_load_once", lap_loads - l0, 1);
    t0 = tick_count;
    repeat (30) @(negedge clk);
    #1;
    check("lap_ticks_continue", tick_count - t0, 3);
    press_hold(B_LAP, 8);
    #1;
    check("lap_back_count", int'(bus.state), int'(ST_COUNT));
    check("lap_back_disp", int'(bus.disp_sel), 0);
    check("no_second_load", lap_loads - l0, 1);

    // Simultaneous start+stop from COUNT resolves to PAUSE; lap ignored there
    repeat (10) @(negedge clk);
    press_hold(B_START | B_STOP, 8);
    check("start_beats_stop", int'(bus.state), int'(ST_PAUSE));
    repeat (10) @(negedge clk);
    press_hold(B_LAP, 8);
    repeat (4) @(negedge clk);
    check("lap_ignored_pause", int'(bus.state), int'(ST_PAUSE));
    press_hold(B_STOP, 8);
    check("pause_stop_idle", int'(bus.state), int'(ST_IDLE));
    check("idle_cnt_clr", int'(bus.cnt_clr), 1);
    repeat (10) @(negedge clk);
    press_hold(B_LAP | B_STOP, 8);
    repeat (4) @(negedge clk);
    check("idle_ignores_lap_stop", int'(bus.state), int'(ST_IDLE));

    // Reset mid-COUNT at prescaler 5, start held through reset release
    repeat (10) @(negedge clk);
    press_hold(B_START, 8);
    wait_tick();
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_state",    int'(bus.state),    0);
    check("midrst_cnt_clr",  int'(bus.cnt_clr),  1);
    check("midrst_cnt_en",   int'(bus.cnt_en),   0);
    check("midrst_lap_load", int'(bus.lap_load), 0);
    check("midrst_disp_sel", int'(bus.disp_sel), 0);
    set_buttons(B_START);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 10) set_buttons(3'b000);
      if (bus.state == ST_COUNT && lat == 0) lat = i;
    end
    #1;
    check("held_thru_reset_latency", lat, 7);
    check("restart_first_tick", first_tick, 10);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
